// File: rtl/spi_minion_flow_adapter.sv
// Sequences SPI minion transactions into RX/TX val/rdy queues, using the flag
// bits carried in every packet for credit-style flow control in both directions.
module spi_minion_flow_adapter #(
  parameter int unsigned NBITS       = 34,
  parameter int unsigned NUM_ENTRIES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seize,
  input  logic             serve,
  input  logic [NBITS-1:0] from_minion,
  output logic [NBITS-1:0] to_minion,
  output logic [NBITS-3:0] recv_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
  input  logic [NBITS-3:0] send_msg,
  input  logic             send_val,
  output logic             send_rdy,
  output logic [7:0]       drop_count
);

  localparam int unsigned PW   = NBITS - 2;
  localparam int unsigned PTRW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned CNTW = $clog2(NUM_ENTRIES + 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e state_q, state_d;
  logic   snap_val_q, snap_val_d;
  logic   snap_spc_q, snap_spc_d;
  logic [7:0] drop_q, drop_d;

  logic [PW-1:0]   rx_mem_q [NUM_ENTRIES];
  logic [PTRW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CNTW-1:0] rx_cnt_q, rx_cnt_d;

  logic [PW-1:0]   tx_mem_q [NUM_ENTRIES];
  logic [PTRW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CNTW-1:0] tx_cnt_q, tx_cnt_d;

  logic rx_full, rx_empty, tx_full, tx_empty;
  logic m_val, m_rdy, serve_act;
  logic rx_push, rx_pop, tx_push, tx_pop, drop_evt;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(NUM_ENTRIES - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign rx_full  = (rx_cnt_q == CNTW'(NUM_ENTRIES));
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CNTW'(NUM_ENTRIES));
  assign tx_empty = (tx_cnt_q == '0);

  assign m_val = from_minion[NBITS-1];
  assign m_rdy = from_minion[NBITS-2];

  // A coincident seize wins: the serve is discarded and a new transaction starts.
  assign serve_act = serve && !seize && (state_q == ACTIVE);

  assign rx_push  = serve_act && m_val && snap_spc_q;
  assign drop_evt = serve_act && m_val && !snap_spc_q;
  assign tx_pop   = serve_act && snap_val_q && m_rdy;
  assign rx_pop   = recv_val && recv_rdy;
  assign tx_push  = send_val && send_rdy;

  assign recv_val  = !rx_empty;
  assign recv_msg  = rx_mem_q[rx_rd_q];
  assign send_rdy  = reset && !tx_full;
  assign to_minion = {!tx_empty, !rx_full, tx_empty ? '0 : tx_mem_q[tx_rd_q]};
  assign drop_count = drop_q;

  always_comb begin
    state_d    = state_q;
    snap_val_d = snap_val_q;
    snap_spc_d = snap_spc_q;
    if (seize) begin
      state_d    = ACTIVE;
      snap_val_d = !tx_empty;
      snap_spc_d = !rx_full;
    end else if (serve_act) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_evt && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_comb begin
    rx_wr_d  = rx_push ? ptr_inc(rx_wr_q) : rx_wr_q;
    rx_rd_d  = rx_pop  ? ptr_inc(rx_rd_q) : rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CNTW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CNTW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_comb begin
    tx_wr_d  = tx_push ? ptr_inc(tx_wr_q) : tx_wr_q;
    tx_rd_d  = tx_pop  ? ptr_inc(tx_rd_q) : tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CNTW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CNTW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      snap_val_q <= 1'b0;
      snap_spc_q <= 1'b0;
      drop_q     <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      snap_val_q <= snap_val_d;
      snap_spc_q <= snap_spc_d;
      drop_q     <= drop_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= from_minion[PW-1:0];
    if (tx_push) tx_mem_q[tx_wr_q] <= send_msg;
  end

endmodule

// File: tb/tb_spi_minion_flow_adapter.sv
// Directed bench for spi_minion_flow_adapter with queue-based RX/TX scoreboards.
module tb_spi_minion_flow_adapter;

  localparam int NB = 34;
  localparam int PW = NB - 2;
  localparam int NE = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          seize, serve;
  logic [NB-1:0] from_minion, to_minion;
  logic [PW-1:0] recv_msg, send_msg;
  logic          recv_val, recv_rdy, send_val, send_rdy;
  logic [7:0]    drop_count;

  int checks = 0;
  int errors = 0;
  int drops  = 0;
  logic [PW-1:0] rx_exp[$];
  logic [PW-1:0] tx_exp[$];

  spi_minion_flow_adapter #(.NBITS(NB), .NUM_ENTRIES(NE)) dut (
    .clk        (clk),
    .reset      (reset),
    .seize      (seize),
    .serve      (serve),
    .from_minion(from_minion),
    .to_minion  (to_minion),
    .recv_msg   (recv_msg),
    .recv_val   (recv_val),
    .recv_rdy   (recv_rdy),
    .send_msg   (send_msg),
    .send_val   (send_val),
    .send_rdy   (send_rdy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] exp_tom();
    logic [PW-1:0] pl;
    pl = (tx_exp.size() != 0) ? tx_exp[0] : '0;
    return {tx_exp.size() != 0, rx_exp.size() < NE, pl};
  endfunction

  task automatic tx_send(input logic [PW-1:0] d);
    send_val = 1'b1;
    send_msg = d;
    chk("send_rdy", send_rdy, tx_exp.size() < NE);
    tick();
    if (tx_exp.size() < NE) tx_exp.push_back(d);
    send_val = 1'b0;
  endtask

  task automatic xact(input logic mv, input logic mr, input logic [PW-1:0] pay, input string tag);
    logic sv, ss;
    seize = 1'b1;
    tick();
    seize = 1'b0;
    sv = (tx_exp.size() != 0);
    ss = (rx_exp.size() < NE);
    chk({tag, "_to_minion"}, to_minion, exp_tom());
    tick();
    serve       = 1'b1;
    from_minion = {mv, mr, pay};
    tick();
    serve       = 1'b0;
    from_minion = '0;
    if (mv) begin
      if (ss) rx_exp.push_back(pay);
      else if (drops < 255) drops++;
    end
    if (sv && mr) void'(tx_exp.pop_front());
    chk({tag, "_drop_count"}, drop_count, drops);
    chk({tag, "_recv_val"}, recv_val, rx_exp.size() != 0);
  endtask

  task automatic drain_one(input string tag);
    logic [PW-1:0] e;
    e = (rx_exp.size() != 0) ? rx_exp.pop_front() : '0;
    chk({tag, "_val"}, recv_val, 1'b1);
    chk({tag, "_msg"}, recv_msg, e);
    recv_rdy = 1'b1;
    tick();
    recv_rdy = 1'b0;
  endtask

  initial begin
    reset = 1'b0; seize = 1'b0; serve = 1'b0; from_minion = '0;
    recv_rdy = 1'b0; send_msg = '0; send_val = 1'b0;

    // reset and idle state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_send_rdy_low", send_rdy, 1'b0);
    chk("rst_recv_val", recv_val, 1'b0);
    chk("rst_to_minion", to_minion, {1'b0, 1'b1, 32'h0});
    chk("rst_drop", drop_count, 8'd0);
    reset = 1'b1;
    tick();
    chk("idle_send_rdy", send_rdy, 1'b1);
    chk("idle_to_minion", to_minion, {1'b0, 1'b1, 32'h0});

    // master -> chip single payload
    xact(1'b1, 1'b0, 32'h5A, "rx5A");
    drain_one("rx5A_drain");
    chk("rx5A_empty", recv_val, 1'b0);

    // chip -> master: popped with m_rdy=1, retained with m_rdy=0
    tx_send(32'h33);
    chk("tx33_to_minion", to_minion, {1'b1, 1'b1, 32'h33});
    xact(1'b0, 1'b1, 32'h0, "tx33_pop");
    chk("tx33_popped", to_minion, {1'b0, 1'b1, 32'h0});
    tx_send(32'h33);
    xact(1'b0, 1'b0, 32'h0, "tx33_hold");
    chk("tx33_retained", to_minion, {1'b1, 1'b1, 32'h33});
    xact(1'b0, 1'b1, 32'h0, "tx33_resend");

    // TX full: send_rdy drops, head stable across a later push
    tx_send(32'hA1);
    tx_send(32'hB2);
    chk("tx_full_rdy", send_rdy, 1'b0);
    tx_send(32'hC3);
    xact(1'b0, 1'b1, 32'h0, "txA1_pop");
    chk("txB2_head", to_minion, exp_tom());
    xact(1'b0, 1'b1, 32'h0, "txB2_pop");

    // RX overflow with consumer stalled
    xact(1'b1, 1'b0, 32'h1, "ov1");
    xact(1'b1, 1'b0, 32'h2, "ov2");
    xact(1'b1, 1'b0, 32'h3, "ov3");
    chk("ov_drop_one", drop_count, 8'd1);
    drain_one("ov_d1");
    drain_one("ov_d2");
    chk("ov_empty", recv_val, 1'b0);

    // stray serve while idle is ignored
    serve = 1'b1; from_minion = {1'b1, 1'b1, 32'h77};
    tick();
    serve = 1'b0; from_minion = '0;
    chk("stray_recv_val", recv_val, 1'b0);
    chk("stray_drop", drop_count, drops);

    // double seize then one serve -> one push
    seize = 1'b1; tick(); seize = 1'b0; tick();
    xact(1'b1, 1'b0, 32'h44, "dbl_seize");
    drain_one("dbl_drain");
    chk("dbl_empty", recv_val, 1'b0);

    // reset mid-transaction
    tx_send(32'h11);
    seize = 1'b1; tick(); seize = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_send_rdy", send_rdy, 1'b0);
    chk("midrst_to_minion", to_minion, {1'b0, 1'b1, 32'h0});
    tick();
    reset = 1'b1;
    tx_exp.delete(); rx_exp.delete(); drops = 0;
    tick();
    serve = 1'b1; from_minion = {1'b1, 1'b1, 32'h99};
    tick();
    serve = 1'b0; from_minion = '0;
    chk("postrst_recv_val", recv_val, 1'b0);
    chk("postrst_drop", drop_count, 8'd0);
    chk("postrst_to_minion", to_minion, {1'b0, 1'b1, 32'h0});

    // saturating drop counter
    xact(1'b1, 1'b0, 32'hE1, "sat_fill1");
    xact(1'b1, 1'b0, 32'hE2, "sat_fill2");
    for (int i = 0; i < 258; i++) xact(1'b1, 1'b0, 32'(i), "sat");
    chk("sat_drop_255", drop_count, 8'd255);
    drain_one("sat_d1");
    drain_one("sat_d2");
    chk("sat_empty", recv_val, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
